// File: rtl/usb3_pkg.sv
// usb3_pkg: shared widths, default packet length and FSM encoding for the USB3 packet buffer
package usb3_pkg;
    localparam int USB_DATA_W    = 32;
    localparam int PKT_WORDS_DEF = 256;
    typedef enum logic [1:0] {IDLE, ARMED, SEND} pkt_state_t;
endpackage

// File: rtl/usb3_sdp_ram.sv
// usb3_sdp_ram: simple dual-port RAM with one write port and one registered read port
//   clk                       : write and read clock
//   i_we, i_waddr, i_wdata    : write port
//   i_re, i_raddr             : read request
//   o_rdata                   : read data, one cycle after i_re
module usb3_sdp_ram
    import usb3_pkg::*;
#(
    parameter int DATA_W = USB_DATA_W,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/usb3_pkt_buffer.sv
// usb3_pkt_buffer: FIFO that commits a sample stream to the slave-FIFO writer in full or timed-out packets
//   clk125m, rst                 : clock, synchronous active-high reset
//   in_data, in_valid, in_ready  : sample input, dropped (overflow sticky) when full
//   pkt_ready, pkt_len, pkt_take : committed packet offer and its acceptance pulse
//   out_rd, out_data, out_valid, out_last : pull side, one-cycle read latency
//   overflow, level              : sticky drop flag, FIFO occupancy
module usb3_pkt_buffer
    import usb3_pkg::*;
#(
    parameter int DATA_W      = USB_DATA_W,
    parameter int DEPTH_LOG2  = 10,
    parameter int PKT_WORDS   = PKT_WORDS_DEF,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                             clk125m,
    input  logic                             rst,
    input  logic [DATA_W-1:0]                in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic                             pkt_ready,
    output logic [$clog2(PKT_WORDS+1)-1:0]   pkt_len,
    input  logic                             pkt_take,
    input  logic                             out_rd,
    output logic [DATA_W-1:0]                out_data,
    output logic                             out_valid,
    output logic                             out_last,
    output logic                             overflow,
    output logic [DEPTH_LOG2:0]              level
);
    localparam int PW = DEPTH_LOG2 + 1;
    localparam int LW = $clog2(PKT_WORDS + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PW-1:0] FULL  = PW'(2 ** DEPTH_LOG2);
    localparam logic [PW-1:0] PKT_N = PW'(PKT_WORDS);
    localparam logic [TW-1:0] TMO   = TW'(TIMEOUT_CYC);

    pkt_state_t        r_state, w_state_nxt;
    logic [PW-1:0]     r_wptr, r_rptr, r_level, w_unc;
    logic [LW-1:0]     r_len, r_rem;
    logic [TW-1:0]     r_tmr;
    logic              r_vld, r_last, r_ovf;
    logic              w_wr, w_pop, w_full_pkt, w_commit;
    logic [DATA_W-1:0] w_rdata;

    assign in_ready   = r_level != FULL;
    assign w_wr       = in_valid && in_ready;
    assign w_pop      = r_state == SEND && out_rd && r_rem != '0;
    // words still owed to the packet in flight are not available for a new commit
    assign w_unc      = r_level - (r_state == SEND ? PW'(r_rem) : '0);
    assign w_full_pkt = w_unc >= PKT_N;
    assign w_commit   = w_full_pkt || (w_unc != '0 && r_tmr == TMO);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    w_state_nxt = w_commit ? ARMED : IDLE;
            ARMED:   w_state_nxt = pkt_take ? SEND : ARMED;
            SEND:    w_state_nxt = (r_rem == '0 || (w_pop && r_rem == LW'(1))) ? IDLE : SEND;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk125m) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk125m) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_len   <= '0;
            r_rem   <= '0;
            r_tmr   <= '0;
            r_vld   <= 1'b0;
            r_last  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_wptr  <= r_wptr + PW'(w_wr);
            r_rptr  <= r_rptr + PW'(w_pop);
            r_level <= r_level + PW'(w_wr) - PW'(w_pop);
            r_ovf   <= r_ovf || (in_valid && !in_ready);
            // idle timer only runs while a partial packet is waiting
            r_tmr   <= (w_wr || w_unc == '0 || w_full_pkt) ? '0 : (r_tmr == TMO ? r_tmr : r_tmr + TW'(1));
            r_vld   <= w_pop;
            r_last  <= w_pop && r_rem == LW'(1);
            if (r_state == IDLE && w_commit) r_len <= w_full_pkt ? LW'(PKT_WORDS) : LW'(w_unc);
            if (r_state == ARMED && pkt_take) r_rem <= r_len;
            else if (w_pop) r_rem <= r_rem - LW'(1);
        end
    end

    usb3_sdp_ram #(.DATA_W(DATA_W), .ADDR_W(DEPTH_LOG2)) u_ram (
        .clk     (clk125m),
        .i_we    (w_wr),
        .i_waddr (r_wptr[DEPTH_LOG2-1:0]),
        .i_wdata (in_data),
        .i_re    (w_pop),
        .i_raddr (r_rptr[DEPTH_LOG2-1:0]),
        .o_rdata (w_rdata)
    );

    assign pkt_ready = r_state == ARMED;
    assign pkt_len   = r_len;
    assign out_data  = r_vld ? w_rdata : '0;
    assign out_valid = r_vld;
    assign out_last  = r_last;
    assign overflow  = r_ovf;
    assign level     = r_level;
endmodule

// File: tb/tb_usb3_pkt_buffer.sv
// tb_usb3_pkt_buffer: directed self-checking bench for usb3_pkt_buffer
module tb_usb3_pkt_buffer;
    logic        clk125m = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        pkt_ready;
    logic [8:0]  pkt_len;
    logic        pkt_take = 1'b0;
    logic        out_rd = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        overflow;
    logic [10:0] level;
    int          n_chk = 0;
    int          n_err = 0;

    usb3_pkt_buffer dut (
        .clk125m   (clk125m),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pkt_ready (pkt_ready),
        .pkt_len   (pkt_len),
        .pkt_take  (pkt_take),
        .out_rd    (out_rd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .overflow  (overflow),
        .level     (level)
    );

    always #4 clk125m = ~clk125m;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic wr_burst(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk125m);
            in_valid = 1'b1;
            in_data  = first + i;
        end
        @(negedge clk125m);
        in_valid = 1'b0;
    endtask

    task automatic wait_rdy(input string tag, input int max);
        int k = 0;
        while (!pkt_ready && k < max) begin
            @(negedge clk125m);
            k++;
        end
        chk(tag, pkt_ready, 1);
    endtask

    task automatic read_pkt(input string tag, input int first, input int len);
        int got = 0;
        int cyc = 0;
        pkt_take = 1'b1;
        @(negedge clk125m);
        pkt_take = 1'b0;
        out_rd   = 1'b1;
        while (got < len && cyc < len + 10) begin
            @(negedge clk125m);
            cyc++;
            if (out_valid) begin
                chk({tag, " data"}, out_data, first + got);
                chk({tag, " last"}, out_last, got == len - 1);
                got++;
            end
        end
        out_rd = 1'b0;
        chk({tag, " count"}, got, len);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr, nxt, cyc, npk, k, got, c;
        repeat (3) @(negedge clk125m);
        chk("rst in_ready", in_ready, 1);
        chk("rst pkt_ready", pkt_ready, 0);
        chk("rst pkt_len", pkt_len, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_last", out_last, 0);
        chk("rst out_data", out_data, 0);
        chk("rst overflow", overflow, 0);
        chk("rst level", level, 0);
        rst = 1'b0;

        // two back-to-back full packets with a continuous stream
        wr = 0; nxt = 1; cyc = 0; npk = 0;
        out_rd = 1'b1;
        while (nxt <= 512 && cyc < 3000) begin
            @(negedge clk125m);
            cyc++;
            if (out_valid) begin
                chk("t1 data", out_data, nxt);
                chk("t1 last", out_last, nxt % 256 == 0);
                nxt++;
            end
            pkt_take = pkt_ready;
            if (pkt_ready) begin
                chk("t1 len", pkt_len, 256);
                npk++;
            end
            in_valid = wr < 512;
            in_data  = wr + 1;
            if (wr < 512) wr++;
        end
        in_valid = 1'b0; pkt_take = 1'b0; out_rd = 1'b0;
        chk("t1 words", nxt, 513);
        chk("t1 packets", npk, 2);
        chk("t1 overflow", overflow, 0);
        chk("t1 level", level, 0);

        // short packet after idle timeout
        wr_burst(1, 10);
        k = 0;
        while (!pkt_ready && k < 1100) begin
            @(negedge clk125m);
            k++;
        end
        chk("t2 latency", k, 1001);
        chk("t2 len", pkt_len, 10);
        read_pkt("t2", 1, 10);
        chk("t2 level", level, 0);

        // overflow: 1025 writes, no reads
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk125m);
            in_valid = 1'b1;
            in_data  = i + 1;
        end
        @(negedge clk125m);
        chk("t3 level full", level, 1024);
        chk("t3 in_ready", in_ready, 0);
        chk("t3 ovf before", overflow, 0);
        in_data = 1025;
        @(negedge clk125m);
        in_valid = 1'b0;
        chk("t3 ovf set", overflow, 1);
        chk("t3 level held", level, 1024);
        repeat (5) @(negedge clk125m);
        chk("t3 ovf sticky", overflow, 1);
        chk("t3 rdy", pkt_ready, 1);
        chk("t3 len", pkt_len, 256);
        read_pkt("t3 p0", 1, 256);
        for (int j = 1; j < 4; j++) begin
            wait_rdy("t3 drain rdy", 10);
            chk("t3 drain len", pkt_len, 256);
            read_pkt("t3 drain", 1 + 256 * j, 256);
        end
        chk("t3 ovf end", overflow, 1);
        chk("t3 level end", level, 0);

        // simultaneous write and pop while sending
        wr_burst(1, 256);
        wait_rdy("t4 rdy", 10);
        chk("t4 len", pkt_len, 256);
        pkt_take = 1'b1;
        @(negedge clk125m);
        pkt_take = 1'b0; out_rd = 1'b1; in_valid = 1'b1; in_data = 1001;
        got = 0; c = 0;
        while (got < 256 && c < 400) begin
            @(negedge clk125m);
            c++;
            if (out_valid) begin
                chk("t4 data", out_data, got + 1);
                chk("t4 last", out_last, got == 255);
                got++;
            end
            if (c <= 50) chk("t4 level", level, 256);
            if (c == 100) begin
                chk("t4 len held", pkt_len, 256);
                chk("t4 rdy low", pkt_ready, 0);
            end
            in_valid = c < 50;
            in_data  = 1001 + c;
        end
        out_rd = 1'b0; in_valid = 1'b0;
        chk("t4 count", got, 256);
        chk("t4 level rest", level, 50);
        wait_rdy("t4 rdy2", 1300);
        chk("t4 len2", pkt_len, 50);
        read_pkt("t4b", 1001, 50);

        // reset in the middle of a packet
        wr_burst(1, 256);
        wait_rdy("t5 rdy", 10);
        pkt_take = 1'b1;
        @(negedge clk125m);
        pkt_take = 1'b0; out_rd = 1'b1;
        repeat (100) @(negedge clk125m);
        chk("t5 level pre", level, 156);
        chk("t5 valid pre", out_valid, 1);
        chk("t5 ovf pre", overflow, 1);
        rst = 1'b1; out_rd = 1'b0;
        @(negedge clk125m);
        rst = 1'b0;
        chk("t5 level", level, 0);
        chk("t5 pkt_ready", pkt_ready, 0);
        chk("t5 out_valid", out_valid, 0);
        chk("t5 overflow", overflow, 0);
        chk("t5 in_ready", in_ready, 1);
        wr_burst(2001, 256);
        wait_rdy("t5 rdy2", 10);
        chk("t5 len", pkt_len, 256);
        read_pkt("t5b", 2001, 256);

        // pkt_take in IDLE and out_rd in ARMED are ignored
        wr_burst(3001, 5);
        pkt_take = 1'b1;
        @(negedge clk125m);
        pkt_take = 1'b0; out_rd = 1'b1;
        chk("t6 idle rdy", pkt_ready, 0);
        chk("t6 idle valid", out_valid, 0);
        chk("t6 idle level", level, 5);
        @(negedge clk125m);
        out_rd = 1'b0;
        chk("t6 idle rd valid", out_valid, 0);
        wait_rdy("t6 rdy", 1100);
        chk("t6 len", pkt_len, 5);
        out_rd = 1'b1;
        repeat (3) begin
            @(negedge clk125m);
            chk("t6 armed valid", out_valid, 0);
            chk("t6 armed rdy", pkt_ready, 1);
        end
        out_rd = 1'b0;
        chk("t6 armed level", level, 5);
        read_pkt("t6", 3001, 5);
        @(negedge clk125m);
        chk("t6 level end", level, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/usb3_pkt_buffer.md
Name: usb3_pkt_buffer

Overview:
- Upstream feeder for the CYUSB3014 slave-FIFO write controller (usb3_datastream).
- Buffers a continuous 32-bit sample stream in an on-chip FIFO and commits it to the writer in packets of PKT_WORDS words.
- A trailing partial packet is committed after an idle timeout, so the writer can close it with pktend_n.
- Writer side uses a commit-then-pull handshake.

Parameters:
- DATA_W, 32, sample and USB word width
- DEPTH_LOG2, 10, FIFO depth is 2^DEPTH_LOG2 = 1024 words
- PKT_WORDS, 256, full packet length in words
- TIMEOUT_CYC, 1000, idle cycles before a partial packet is committed

Ports:
- clk125m  in  1  single 125 MHz clock; all logic is on its rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  32  sample word
- in_valid  in  1  sample present this cycle
- in_ready  out  1  FIFO not full
- pkt_ready  out  1  a packet is committed and waiting for the writer
- pkt_len  out  9  words in the committed packet, 1..256; valid while pkt_ready
- pkt_take  in  1  one-cycle pulse from the writer accepting the committed packet
- out_rd  in  1  pop one word of the accepted packet
- out_data  out  32  popped word, 1-cycle read latency
- out_valid  out  1  out_data valid this cycle
- out_last  out  1  coincident with out_valid on the packet's final word
- overflow  out  1  sticky; a sample was dropped
- level  out  11  current FIFO occupancy, 0..1024

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - all outputs 0 except in_ready=1
  - FIFO pointers, level, idle timer, remaining-word counter and state are cleared
  - state returns to IDLE; applies mid-packet as well, with no partial flush
- Write:
  - in_valid & in_ready stores in_data at the write pointer.
  - in_valid & !in_ready drops the word and sets overflow, which stays set until rst.
- Level:
  - +1 on write only, −1 on pop only, unchanged on a simultaneous write and pop.
  - in_ready = (level != 2^DEPTH_LOG2).
- Pointers: DEPTH_LOG2+1 bits, natural wrap-around.
- Idle timer:
  - Counts cycles with no accepted write while 0 < uncommitted words < PKT_WORDS.
  - Resets to 0 on any accepted write; saturates at TIMEOUT_CYC.
- FSM states: IDLE, ARMED, SEND.
  - IDLE → ARMED:
    - Full packet when uncommitted ≥ PKT_WORDS: pkt_len = PKT_WORDS.
    - Short packet when uncommitted > 0 and the timer reaches TIMEOUT_CYC: pkt_len = uncommitted count at that cycle.
    - pkt_ready rises the cycle after the condition; pkt_len is latched then.
  - ARMED:
    - pkt_ready=1 and pkt_len held stable.
    - pkt_take moves to SEND and loads the remaining counter with pkt_len.
    - Words written while ARMED do not change pkt_len.
  - SEND:
    - pkt_ready=0.
    - out_rd with remaining > 0 pops one word; out_data and out_valid appear the next cycle; remaining decrements.
    - out_last=1 on the word whose pop took remaining from 1 to 0.
    - After that word is issued, returns to IDLE; a new commit may occur the next cycle.
- Ignored inputs:
  - out_rd when not in SEND, or when remaining = 0 (no pop, no out_valid).
  - pkt_take when not in ARMED.
- Uncommitted count = level − remaining (in SEND), else level.
- Back-to-back full packets: there is no dead cycle beyond the IDLE → ARMED registration cycle.
- FIFO memory is a simple dual-port RAM with registered read, suitable for block RAM inference.

Decomposition:
- Shared package usb3_pkg holds:
  - USB_DATA_W = 32
  - PKT_WORDS_DEF = 256
  - FSM state encoding (IDLE, ARMED, SEND)
- One sub-module: usb3_sdp_ram, a parameterised simple dual-port RAM (write port, registered read port).
- Pointers, level, timer and FSM stay in usb3_pkt_buffer.

Test Plan:
- 512 words 1..512, in_valid continuous; writer takes each packet on pkt_ready and pops every cycle → two packets of pkt_len 256; out_data is 1..256 then 257..512; out_last on 256 and 512; overflow=0; level=0 at end.
- 10 words then idle → pkt_ready rises TIMEOUT_CYC+1 cycles after the last write with pkt_len=10; data 1..10; out_last on word 10.
- 1025 words with no reads → level=1024 and in_ready=0 after word 1024; word 1025 is dropped; overflow=1 and stays set; the first packet still reads 1..256.
- Simultaneous write and pop in SEND for 50 cycles → level constant; pkt_len of the packet being sent is unchanged; the next commit carries the later words in order.
- rst asserted for one cycle in SEND after 100 pops → next cycle level=0, pkt_ready=0, out_valid=0, overflow=0, in_ready=1; a new 256-word burst produces a clean packet.
- pkt_take while in IDLE, and out_rd while in ARMED → no state change, no out_valid, level unchanged.
